// File: rtl/tdm_demux.sv
// tdm_demux -- receive side of a slot-multiplexed link.
//
// Accepts one W-bit beat per valid cycle. A beat flagged in_sof starts a new
// frame in slot 0. The following beats fill slots 1..N_CH-1 of a staging
// array. The beat that fills the last slot publishes the whole frame on
// out_data, together with a one-cycle out_valid pulse.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous reset, active low
//   in_valid   beat present on in_data
//   in_sof     beat is slot 0 of a new frame (qualified by in_valid)
//   in_data    beat payload, W bits
//   out_valid  one-cycle pulse: out_data holds a newly completed frame
//   out_data   last completed frame; channel k at bits [k*W +: W]
//   frame_err  one-cycle pulse: orphan beat in IDLE, or sof arrived mid-frame
//   slot_idx   slot the next non-sof beat will fill; 0 in IDLE
module tdm_demux #(
   parameter int N_CH = 4,
   parameter int W    = 8,
   localparam int SW  = $clog2(N_CH)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                in_valid,
   input  logic                in_sof,
   input  logic [W-1:0]        in_data,
   output logic                out_valid,
   output logic [N_CH*W-1:0]   out_data,
   output logic                frame_err,
   output logic [SW-1:0]       slot_idx
);

   typedef enum logic {IDLE, COLLECT} state_t;

   localparam logic [SW-1:0] LAST = SW'(N_CH - 1);

   state_t                     state;
   logic [SW-1:0]              slot;
   logic [N_CH-1:0][W-1:0]     staging;

   assign slot_idx = slot;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         slot      <= '0;
         staging   <= '0;
         out_data  <= '0;
         out_valid <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         // Both flags are single-cycle pulses.
         out_valid <= 1'b0;
         frame_err <= 1'b0;
         if (in_valid) begin
            case (state)
               IDLE: begin
                  if (in_sof) begin
                     staging[0] <= in_data;
                     slot       <= SW'(1);
                     state      <= COLLECT;
                  end else begin
                     // A beat with no frame to belong to is dropped.
                     frame_err <= 1'b1;
                  end
               end
               COLLECT: begin
                  if (in_sof) begin
                     // Early sof: discard the partial frame and restart from
                     // this beat. Stale upper slots are always overwritten
                     // before the next completion, so they are left in place.
                     frame_err  <= 1'b1;
                     staging[0] <= in_data;
                     slot       <= SW'(1);
                  end else if (slot == LAST) begin
                     // The last beat goes straight to the output. It is never
                     // staged.
                     out_data  <= {in_data, staging[N_CH-2:0]};
                     out_valid <= 1'b1;
                     slot      <= '0;
                     state     <= IDLE;
                  end else begin
                     staging[slot] <= in_data;
                     slot          <= slot + SW'(1);
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_tdm_demux.sv
module tb_tdm_demux;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_sof;
   logic [7:0]  in_data;
   logic        out_valid;
   logic [31:0] out_data;
   logic        frame_err;
   logic [1:0]  slot_idx;

   int total = 0;
   int bad   = 0;

   tdm_demux #(.N_CH(4), .W(8)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_sof    (in_sof),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_data  (out_data),
      .frame_err (frame_err),
      .slot_idx  (slot_idx)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Drive one cycle on the falling edge. Then wait just past the rising edge
   // that samples it, so the outputs reflect this beat.
   task automatic step(input logic v, input logic s, input logic [7:0] d);
      @(negedge clk);
      in_valid = v;
      in_sof   = s;
      in_data  = d;
      @(posedge clk);
      #1;
   endtask

   // Check every output after a step.
   task automatic expect_out(input string tag, input logic ov, input logic [31:0] od,
                             input logic fe, input logic [1:0] si);
      chk({tag, ".ov"},  32'(out_valid), 32'(ov));
      chk({tag, ".od"},  out_data,        od);
      chk({tag, ".fe"},  32'(frame_err), 32'(fe));
      chk({tag, ".si"},  32'(slot_idx),  32'(si));
   endtask

   initial begin
      rst = 1'b0; in_valid = 1'b0; in_sof = 1'b0; in_data = 8'h00;
      #3;
      expect_out("reset", 1'b0, 32'h0, 1'b0, 2'd0);
      @(negedge clk); rst = 1'b1;

      // Early sof abandons the partial frame; out_data stays 0 until completion.
      step(1, 1, 8'h01); expect_out("es1", 0, 32'h0, 0, 2'd1);
      step(1, 0, 8'h02); expect_out("es2", 0, 32'h0, 0, 2'd2);
      step(1, 1, 8'h10); expect_out("es3", 0, 32'h0, 1, 2'd1);
      step(1, 0, 8'h20); expect_out("es4", 0, 32'h0, 0, 2'd2);
      step(1, 0, 8'h30); expect_out("es5", 0, 32'h0, 0, 2'd3);
      step(1, 0, 8'h40); expect_out("es6", 1, 32'h40302010, 0, 2'd0);
      step(0, 0, 8'h00); expect_out("es7", 0, 32'h40302010, 0, 2'd0);

      // Single frame.
      step(1, 1, 8'h11); expect_out("sf1", 0, 32'h40302010, 0, 2'd1);
      step(1, 0, 8'h22); expect_out("sf2", 0, 32'h40302010, 0, 2'd2);
      step(1, 0, 8'h33); expect_out("sf3", 0, 32'h40302010, 0, 2'd3);
      step(1, 0, 8'h44); expect_out("sf4", 1, 32'h44332211, 0, 2'd0);
      step(0, 0, 8'h00); expect_out("sf5", 0, 32'h44332211, 0, 2'd0);

      // Gapped frame: a stall holds everything.
      step(1, 1, 8'h11); expect_out("gp1", 0, 32'h44332211, 0, 2'd1);
      for (int i = 0; i < 3; i++) begin
         step(0, 0, 8'hEE); expect_out("gpa", 0, 32'h44332211, 0, 2'd1);
      end
      step(1, 0, 8'h22); expect_out("gp2", 0, 32'h44332211, 0, 2'd2);
      for (int i = 0; i < 3; i++) begin
         step(0, 1, 8'hEE); expect_out("gpb", 0, 32'h44332211, 0, 2'd2);
      end
      step(1, 0, 8'h33); expect_out("gp3", 0, 32'h44332211, 0, 2'd3);
      for (int i = 0; i < 3; i++) begin
         step(0, 0, 8'hEE); expect_out("gpc", 0, 32'h44332211, 0, 2'd3);
      end
      step(1, 0, 8'h44); expect_out("gp4", 1, 32'h44332211, 0, 2'd0);
      step(0, 0, 8'h00); expect_out("gp5", 0, 32'h44332211, 0, 2'd0);

      // Back-to-back frames.
      step(1, 1, 8'h11); expect_out("bb1", 0, 32'h44332211, 0, 2'd1);
      step(1, 0, 8'h22); expect_out("bb2", 0, 32'h44332211, 0, 2'd2);
      step(1, 0, 8'h33); expect_out("bb3", 0, 32'h44332211, 0, 2'd3);
      step(1, 0, 8'h44); expect_out("bb4", 1, 32'h44332211, 0, 2'd0);
      step(1, 1, 8'hA1); expect_out("bb5", 0, 32'h44332211, 0, 2'd1);
      step(1, 0, 8'hB2); expect_out("bb6", 0, 32'h44332211, 0, 2'd2);
      step(1, 0, 8'hC3); expect_out("bb7", 0, 32'h44332211, 0, 2'd3);
      step(1, 0, 8'hD4); expect_out("bb8", 1, 32'hD4C3B2A1, 0, 2'd0);

      // Orphan beat in IDLE.
      step(1, 0, 8'h5A); expect_out("or1", 0, 32'hD4C3B2A1, 1, 2'd0);
      step(1, 1, 8'h01); expect_out("or2", 0, 32'hD4C3B2A1, 0, 2'd1);
      step(1, 0, 8'h02); expect_out("or3", 0, 32'hD4C3B2A1, 0, 2'd2);
      step(1, 0, 8'h03); expect_out("or4", 0, 32'hD4C3B2A1, 0, 2'd3);
      step(1, 0, 8'h04); expect_out("or5", 1, 32'h04030201, 0, 2'd0);

      // Asynchronous reset mid-frame, asserted between clock edges.
      step(1, 1, 8'h99); expect_out("ar1", 0, 32'h04030201, 0, 2'd1);
      step(1, 0, 8'h88); expect_out("ar2", 0, 32'h04030201, 0, 2'd2);
      #1 rst = 1'b0;
      #1 expect_out("ar3", 0, 32'h0, 0, 2'd0);
      @(negedge clk); in_valid = 1'b0; rst = 1'b1;
      step(1, 1, 8'hAB); expect_out("ar4", 0, 32'h0, 0, 2'd1);
      step(1, 0, 8'hCD); expect_out("ar5", 0, 32'h0, 0, 2'd2);
      step(1, 0, 8'hEF); expect_out("ar6", 0, 32'h0, 0, 2'd3);
      step(1, 0, 8'h12); expect_out("ar7", 1, 32'h12EFCDAB, 0, 2'd0);
      step(0, 0, 8'h00); expect_out("ar8", 0, 32'h12EFCDAB, 0, 2'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/tdm_demux.md
# tdm_demux

Time-division demultiplexer: the receive end of a slot-multiplexed link whose transmit side selects one of N channels per cycle with a mux chain. It accepts one W-bit beat per valid cycle and tracks frame position from a start-of-frame marker. Each beat is steered into its channel's staging register. When a frame is complete, all channels are presented in parallel with a one-cycle valid pulse. It sits directly after the link input register and feeds per-channel consumers.

## Interface
- N_CH, default 4: channels (slots) per frame; legal range ≥ 2.
- W, default 8: bits per channel beat.

- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  reset; asynchronous, active-low.
- in_valid  input  1  beat present on in_data this cycle.
- in_sof  input  1  beat is slot 0 of a new frame; ignored when in_valid=0.
- in_data  input  W  beat payload.
- out_valid  output  1  one-cycle pulse: out_data holds a newly completed frame.
- out_data  output  N_CH*W  last completed frame; channel k at bits [k*W +: W].
- frame_err  output  1  one-cycle pulse: protocol violation detected.
- slot_idx  output  $clog2(N_CH)  slot the next non-sof beat will fill; 0 in IDLE.

## Operation
- Two states, IDLE and COLLECT. Internal storage: slot counter and staging array of N_CH×W.
- IDLE, in_valid=1, in_sof=1: write beat to staging[0]; set slot=1; go to COLLECT.
- IDLE, in_valid=1, in_sof=0: drop beat; pulse frame_err; stay in IDLE.
- COLLECT, in_valid=1, in_sof=0, slot<N_CH-1: write to staging[slot]; increment slot.
- COLLECT, in_valid=1, in_sof=0, slot=N_CH-1:
  - load out_data from staging[0..N_CH-2] plus this beat in the top channel;
  - pulse out_valid; set slot=0; go to IDLE.
- COLLECT, in_valid=1, in_sof=1 (early sof):
  - pulse frame_err; abandon the partial frame (out_data unchanged);
  - write beat to staging[0]; set slot=1; stay in COLLECT.
- in_valid=0 in any state: no change. There is no timeout; a frame may stall indefinitely.
- Stale staging entries from an abandoned frame are never emitted, because every slot is rewritten before the next completion.
- out_data changes only on frame completion and otherwise holds its value.
- slot_idx equals the slot counter.

## Timing
- All outputs are registered.
- Latency: out_valid and the new out_data appear on the edge that samples the last-slot beat, so they are visible in the following cycle.
- frame_err is high for exactly the cycle after the offending beat.
- out_valid and frame_err are never high in the same cycle.
- Throughput: one beat per cycle with zero bubbles. A sof beat on the cycle immediately after a last-slot beat is accepted normally. Back-to-back frames give an out_valid every N_CH cycles.
- Reset values, applied immediately on assertion (including mid-frame): state=IDLE, slot=0, staging=0, out_data=0, out_valid=0, frame_err=0, slot_idx=0.
- First edge after deassertion: normal IDLE behaviour; a sof beat on that edge is accepted.

## Test plan
- Reset then single frame (N_CH=4, W=8): sof+0x11, 0x22, 0x33, 0x44 on consecutive cycles -> next cycle out_valid=1 for 1 cycle, out_data=0x44332211, frame_err never 1.
- Gapped frame: same beats with in_valid=0 for 3 cycles between each -> identical out_data; out_valid one cycle after 0x44; slot_idx steps 1,2,3,0.
- Back-to-back frames: 0x11..0x44, then sof+0xA1, 0xB2, 0xC3, 0xD4 with no gaps -> out_valid pulses 4 cycles apart; out_data 0x44332211 then 0xD4C3B2A1.
- Early sof: sof+0x01, 0x02, then sof+0x10, 0x20, 0x30, 0x40 -> frame_err pulse after the second sof; out_data stays 0 until 0x40302010 with out_valid.
- Orphan beat: in IDLE drive in_valid=1, in_sof=0, 0x5A -> frame_err pulse, out_valid=0, slot_idx=0; a following full frame completes normally.
- Async reset mid-frame: assert rst low between clock edges after 2 beats -> all outputs 0 immediately; after release, a fresh 4-beat frame yields the correct out_data with no frame_err.
